blinker_sequencer: RTL and testbench

Parametrised multi-channel turn-signal/hazard sequencer; successor to the two-channel fixed-rate blinker. All lamps flash in phase from one shared half-period timer. The timer restarts on activation, so the first flash is immediately ON. Adds hazard override, "comfort" minimum-flash completion and a clicker tick. Sits between the debounced switch inputs and the lamp driver outputs.

---
 rtl/blinker_sequencer.sv | 148 ++++++++++++++
 tb/tb_blinker_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/blinker_sequencer.sv
// Multi-channel turn-signal / hazard sequencer: one shared half-period timer keeps
// every lamp in phase; channels complete a minimum number of flashes after release.
module blinker_sequencer #(
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned HALF_PERIOD     = 25000000,
    parameter int unsigned COMFORT_FLASHES = 3
) (
    input  logic              c50M,
    input  logic              resetN,
    input  logic [NUM_CH-1:0] blinkReq,
    input  logic              hazardReq,
    output logic [NUM_CH-1:0] lampOut,
    output logic              active,
    output logic              flashTick
);

    localparam int unsigned    TW     = $clog2(HALF_PERIOD);
    localparam int unsigned    CW     = (COMFORT_FLASHES > 0) ? $clog2(COMFORT_FLASHES + 1) : 1;
    localparam logic [TW-1:0]  T_LAST = TW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0]  C_MAX  = CW'(COMFORT_FLASHES);

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_ACTIVE,
        CH_COMFORT
    } ch_state_e;

    logic [TW-1:0]     timer_q, timer_d;
    logic              phase_q, phase_d;
    logic              haz_q;
    ch_state_e         st_q  [NUM_CH];
    ch_state_e         st_d  [NUM_CH];
    logic [CW-1:0]     cnt_q [NUM_CH];
    logic [CW-1:0]     cnt_d [NUM_CH];
    logic [NUM_CH-1:0] lamp_q, lamp_d;
    logic              active_q, active_d;
    logic              tick_q, tick_d;

    logic              all_idle;
    logic              quiet;
    logic              start;
    logic              wrap;

    // Quiet means nothing was sequencing last cycle: the timer is parked or about to be.
    always_comb begin
        all_idle = 1'b1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (st_q[i] != CH_IDLE) begin
                all_idle = 1'b0;
            end
        end
    end

    assign quiet = all_idle && !haz_q;
    assign start = quiet && ((|blinkReq) || hazardReq);
    assign wrap  = !quiet && (timer_q == T_LAST);

    // State register
    always_ff @(posedge c50M or negedge resetN) begin
        if (!resetN) begin
            timer_q  <= '0;
            phase_q  <= 1'b0;
            haz_q    <= 1'b0;
            lamp_q   <= '0;
            active_q <= 1'b0;
            tick_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                st_q[i]  <= CH_IDLE;
                cnt_q[i] <= '0;
            end
        end else begin
            timer_q  <= timer_d;
            phase_q  <= phase_d;
            haz_q    <= hazardReq;
            lamp_q   <= lamp_d;
            active_q <= active_d;
            tick_q   <= tick_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Next-state: shared timer/phase plus per-channel FSM and flash counters
    always_comb begin
        logic [CW-1:0] cnt_upd;
        cnt_upd = '0;
        timer_d = '0;
        phase_d = 1'b0;
        if (start) begin
            phase_d = 1'b1;
        end else if (!quiet) begin
            timer_d = wrap ? '0 : timer_q + 1'b1;
            phase_d = phase_q ^ wrap;
        end

        for (int unsigned i = 0; i < NUM_CH; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            // A flash completes at an ON->OFF wrap while this channel's lamp was lit.
            cnt_upd  = cnt_q[i];
            if (wrap && phase_q && lamp_q[i] && (cnt_q[i] < C_MAX)) begin
                cnt_upd = cnt_q[i] + 1'b1;
            end
            unique case (st_q[i])
                CH_IDLE: begin
                    if (blinkReq[i]) begin
                        st_d[i] = CH_ACTIVE;
                    end
                end
                CH_ACTIVE: begin
                    cnt_d[i] = cnt_upd;
                    if (!blinkReq[i]) begin
                        st_d[i] = (cnt_upd >= C_MAX) ? CH_IDLE : CH_COMFORT;
                    end
                end
                CH_COMFORT: begin
                    cnt_d[i] = cnt_upd;
                    if (blinkReq[i]) begin
                        st_d[i] = CH_ACTIVE;
                    end else if (cnt_upd >= C_MAX) begin
                        st_d[i] = CH_IDLE;
                    end
                end
                default: st_d[i] = CH_IDLE;
            endcase
            if (st_d[i] == CH_IDLE) begin
                cnt_d[i] = '0;
            end
        end
    end

    // Output next-values; clicker only fires on start or on a phase edge
    always_comb begin
        active_d = !quiet || start;
        lamp_d   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            lamp_d[i] = phase_d && (hazardReq || (st_d[i] != CH_IDLE));
        end
        tick_d = start || (wrap && (lamp_d != lamp_q));
    end

    assign lampOut   = lamp_q;
    assign active    = active_q;
    assign flashTick = tick_q;

endmodule

// File: tb/tb_blinker_sequencer.sv
// Randomised bench for blinker_sequencer against a position-in-period reference model.
module tb_blinker_sequencer;

    localparam int unsigned NCH = 2;
    localparam int unsigned HP  = 4;
    localparam int unsigned CF  = 3;

    logic           c50M = 1'b0;
    logic           resetN;
    logic [NCH-1:0] blinkReq;
    logic           hazardReq;
    logic [NCH-1:0] lampOut;
    logic           active;
    logic           flashTick;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: a channel stays engaged while held, or until it has shown CF flashes.
    bit             m_eng [NCH];
    int             m_cnt [NCH];
    bit             m_prev_haz;
    logic [NCH-1:0] m_lamp;
    bit             m_tick;
    bit             m_active;
    int             m_pos;

    always #5 c50M = ~c50M;

    blinker_sequencer #(
        .NUM_CH         (NCH),
        .HALF_PERIOD    (HP),
        .COMFORT_FLASHES(CF)
    ) dut (
        .c50M     (c50M),
        .resetN   (resetN),
        .blinkReq (blinkReq),
        .hazardReq(hazardReq),
        .lampOut  (lampOut),
        .active   (active),
        .flashTick(flashTick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_eng[i] = 1'b0;
            m_cnt[i] = 0;
        end
        m_prev_haz = 1'b0;
        m_lamp     = '0;
        m_tick     = 1'b0;
        m_active   = 1'b0;
        m_pos      = 0;
    endtask

    task automatic model_edge(input logic [NCH-1:0] b, input logic h);
        logic [NCH-1:0] old_lamp;
        bit quiet, was_on, now_on;
        old_lamp = m_lamp;
        quiet = !m_prev_haz;
        for (int i = 0; i < NCH; i++) begin
            if (m_eng[i]) quiet = 1'b0;
        end
        if (quiet) begin
            if ((|b) || h) begin
                m_pos = 0;
                for (int i = 0; i < NCH; i++) begin
                    m_eng[i] = b[i];
                    m_cnt[i] = 0;
                end
                m_lamp   = b | {NCH{h}};
                m_tick   = 1'b1;
                m_active = 1'b1;
            end else begin
                m_lamp   = '0;
                m_tick   = 1'b0;
                m_active = 1'b0;
            end
        end else begin
            was_on = (m_pos < HP);
            m_pos  = (m_pos + 1) % (2 * HP);
            now_on = (m_pos < HP);
            for (int i = 0; i < NCH; i++) begin
                if (m_eng[i]) begin
                    if (was_on && !now_on && old_lamp[i] && m_cnt[i] < CF) m_cnt[i]++;
                    if (!b[i] && m_cnt[i] >= CF) begin
                        m_eng[i] = 1'b0;
                        m_cnt[i] = 0;
                    end
                end else if (b[i]) begin
                    m_eng[i] = 1'b1;
                end
                m_lamp[i] = now_on && (h || m_eng[i]);
            end
            m_tick   = (was_on != now_on) && (m_lamp != old_lamp);
            m_active = 1'b1;
        end
        m_prev_haz = h;
    endtask

    task automatic step(input logic [NCH-1:0] b, input logic h);
        blinkReq  = b;
        hazardReq = h;
        @(posedge c50M);
        model_edge(b, h);
        @(negedge c50M);
        check("lamp", 32'(lampOut), 32'(m_lamp));
        check("active", 32'(active), 32'(m_active));
        check("tick", 32'(flashTick), 32'(m_tick));
    endtask

    task automatic run(input logic [NCH-1:0] b, input logic h, input int n);
        repeat (n) step(b, h);
    endtask

    // Asserted between edges so the asynchronous clear is observed before any clock.
    task automatic async_reset();
        #2 resetN = 1'b0;
        #1 model_reset();
        check("rst_lamp", 32'(lampOut), 32'(m_lamp));
        check("rst_active", 32'(active), 32'(m_active));
        check("rst_tick", 32'(flashTick), 32'(m_tick));
        @(negedge c50M);
        check("rst_hold_lamp", 32'(lampOut), 32'(m_lamp));
        resetN = 1'b1;
    endtask

    initial begin
        logic [NCH-1:0] rb;
        logic           rh;
        int             rn;
        resetN    = 1'b0;
        blinkReq  = '0;
        hazardReq = 1'b0;
        model_reset();
        #3;
        check("por_lamp", 32'(lampOut), 32'(m_lamp));
        check("por_active", 32'(active), 32'(m_active));
        check("por_tick", 32'(flashTick), 32'(m_tick));
        @(negedge c50M);
        resetN = 1'b1;

        // Held left request, then release after saturating the flash count
        run(2'b01, 1'b0, 42);
        run(2'b00, 1'b0, 12);
        // Short tap: comfort flashes complete on their own
        run(2'b01, 1'b0, 2);
        run(2'b00, 1'b0, 30);
        // Right channel joins mid-OFF without restarting the timer
        run(2'b01, 1'b0, 6);
        run(2'b11, 1'b0, 20);
        run(2'b00, 1'b0, 30);
        // Hazard from idle, then release with no channel requests
        run(2'b00, 1'b1, 12);
        run(2'b00, 1'b0, 6);
        // Reset mid-ON with a held request, then restart and comfort
        run(2'b01, 1'b0, 2);
        async_reset();
        run(2'b01, 1'b0, 10);
        run(2'b00, 1'b0, 30);

        for (int seg = 0; seg < 150; seg++) begin
            rb = 2'($urandom_range(0, 3));
            rh = ($urandom_range(0, 7) == 0);
            rn = $urandom_range(1, 20);
            if ($urandom_range(0, 29) == 0) async_reset();
            run(rb, rh, rn);
            if ($urandom_range(0, 3) == 0) run(2'b00, 1'b0, 24);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
